// File: rtl/uart_tx_ctrl.sv
// Transmit sequencer for the APB UART: pops bytes from the TX FIFO and serialises
// each one as start, LSB-first data, optional parity and 1 or 2 stop bits.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  input  logic                  cts_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  TX,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t                state_reg, state_next;
  logic [DIV_WIDTH-1:0]  baud_cnt_reg, baud_cnt_next;
  logic [DIV_WIDTH-1:0]  div_reg, div_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  parity_bit_reg, parity_bit_next;
  logic                  par_en_reg, par_en_next;
  logic                  two_stop_reg, two_stop_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg;
  logic                  bit_end;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg      <= IDLE;
      baud_cnt_reg   <= '0;
      div_reg        <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_bit_reg <= 1'b0;
      par_en_reg     <= 1'b0;
      two_stop_reg   <= 1'b0;
      tx_reg         <= 1'b1;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      baud_cnt_reg   <= baud_cnt_next;
      div_reg        <= div_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_bit_reg <= parity_bit_next;
      par_en_reg     <= par_en_next;
      two_stop_reg   <= two_stop_next;
      tx_reg         <= tx_next;
      busy_reg       <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next      = state_reg;
    baud_cnt_next   = baud_cnt_reg;
    div_next        = div_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_bit_next = parity_bit_reg;
    par_en_next     = par_en_reg;
    two_stop_next   = two_stop_reg;
    frame_done      = 1'b0;
    bit_end         = (baud_cnt_reg == div_reg);

    case (state_reg)
      IDLE: begin
        if (enable && !fifo_empty && !cts_n) state_next = FETCH;
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        // Frame configuration is frozen here so register writes mid-frame are harmless
        shift_next      = fifo_rd_data;
        parity_bit_next = (^fifo_rd_data) ^ parity_odd;
        div_next        = baud_div;
        par_en_next     = parity_en;
        two_stop_next   = two_stop;
        baud_cnt_next   = '0;
        bit_cnt_next    = '0;
        state_next      = START;
      end
      START, DATA, PARITY, STOP: begin
        baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;
        if (bit_end) begin
          case (state_reg)
            START: begin
              bit_cnt_next = '0;
              state_next   = DATA;
            end
            DATA: begin
              shift_next = shift_reg >> 1;
              if (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
                bit_cnt_next = '0;
                state_next   = par_en_reg ? PARITY : STOP;
              end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
              end
            end
            PARITY: begin
              bit_cnt_next = '0;
              state_next   = STOP;
            end
            default: begin
              // bit_cnt_reg counts stop bits already sent
              if (bit_cnt_reg == CNT_W'(two_stop_reg)) begin
                frame_done = 1'b1;
                state_next = IDLE;
              end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
              end
            end
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // TX is registered from the next state so the line changes on the bit boundary itself
  always_comb begin
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_bit_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign fifo_rd_en = (state_reg == FETCH);
  assign TX         = tx_reg;
  assign busy       = busy_reg;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit sequencer for the APB UART. It pulls bytes from the UART transmit FIFO, generates the bit-rate timing from PCLK, and serialises each byte onto TX as a configurable frame: start, data LSB-first, optional parity, 1 or 2 stop bits. It honours CTS flow control and reports busy and frame-done status back to the APB register block.

Parameters:
DATA_WIDTH, 8, data bits per frame; must match the TX FIFO width.
DIV_WIDTH, 16, width of the baud divisor; one bit period = baud_div+1 PCLK cycles.

Ports:
PCLK  input  1  system clock, all logic on rising edge
PRESET  input  1  asynchronous, active-high reset
enable  input  1  transmitter enable (control register bit)
baud_div  input  DIV_WIDTH  PCLK cycles per bit minus 1
parity_en  input  1  1 = insert parity bit
parity_odd  input  1  1 = odd parity, 0 = even parity
two_stop  input  1  1 = two stop bits, 0 = one
cts_n  input  1  clear-to-send, active-low, already synchronised
fifo_empty  input  1  TX FIFO empty flag
fifo_rd_data  input  DATA_WIDTH  TX FIFO read data, valid the cycle after fifo_rd_en
fifo_rd_en  output  1  TX FIFO pop strobe, one cycle per byte
TX  output  1  serial line, idle high, registered
busy  output  1  1 while a frame is being fetched or sent
frame_done  output  1  one-cycle pulse at the end of the last stop bit

Behaviour:
- Clock and reset: one clock, PCLK. Reset is asynchronous and active-high on PRESET.
- Reset values: TX=1, fifo_rd_en=0, busy=0, frame_done=0, FSM=IDLE, baud counter=0, bit counter=0.
- Reset mid-frame: TX returns high at once (asynchronously). The partial frame is abandoned. The popped byte is lost and not re-fetched.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE -> FETCH: on the edge where enable=1, fifo_empty=0 and cts_n=0. Otherwise stay in IDLE.
- FETCH: lasts exactly 1 cycle, with fifo_rd_en=1 (decoded from state). Next state is LOAD.
- LOAD: lasts 1 cycle.
  - Captures fifo_rd_data into the shift register.
  - Computes parity as the XOR of the data bits; inverted if parity_odd=1.
  - Latches baud_div, parity_en, parity_odd and two_stop for the whole frame. Configuration changes mid-frame have no effect until the next LOAD.
  - Next state is START.
- Latency: condition true at edge N gives fifo_rd_en high in cycle N+1 and TX falling in cycle N+3.
- Bit timing: the baud counter loads 0 on entry to each bit and counts to the latched baud_div. The bit ends on the cycle the counter equals baud_div, so every bit is exactly baud_div+1 cycles. baud_div=0 gives 1 cycle per bit, which is legal. Counter width is DIV_WIDTH and it never wraps within a bit.
- START: TX=0 for one bit period. Next state is DATA.
- DATA: TX = shift register bit 0, shifting right at each bit end. A bit counter counts 0..DATA_WIDTH-1. After the last data bit, next state is PARITY if parity_en, else STOP.
- PARITY: TX = computed parity bit for one bit period. Next state is STOP.
- STOP: TX=1 for 1 bit period, or 2 if two_stop. frame_done=1 in the final cycle of the last stop bit. Next state is IDLE.
- Back-to-back frames: the IDLE cycle after STOP re-evaluates the start condition. Minimum inter-frame gap is therefore 3 PCLK cycles of TX=1 (IDLE, FETCH, LOAD) beyond the stop bits.
- Frame length in cycles from START entry: (1 + DATA_WIDTH + parity_en + 1 + two_stop) × (baud_div+1).
- busy=1 in every state except IDLE. It is registered alongside the state, so it is high from the FETCH cycle through the last STOP cycle.
- Flow control and enable are sampled only in IDLE:
  - cts_n rising or enable falling mid-frame does not truncate the frame; the current frame always completes.
  - No new frame starts while cts_n=1 or enable=0.
- fifo_empty is sampled only in IDLE. fifo_rd_en is never asserted while fifo_empty=1.

Test Plan:
- Reset, then enable=1, cts_n=0, baud_div=3, no parity, 1 stop; push 0x55 -> one fifo_rd_en pulse. From the first TX=0 cycle, TX holds 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each value for exactly 4 cycles; frame_done pulses in cycle 40; busy falls the next cycle.
- baud_div=0, parity_en=1, parity_odd=0, two_stop=1, byte 0x07 -> bit sequence start 0, data 1,1,1,0,0,0,0,0, parity 1, stop 1,1; 12 cycles total.
- Same with parity_odd=1 and byte 0x00 -> parity bit 1; with byte 0x01 -> parity bit 0.
- FIFO holds 3 bytes, cts_n held 1 -> no fifo_rd_en and TX stays 1. Drop cts_n to 0 -> 3 frames separated by exactly 3 idle-high cycles. Raise cts_n during frame 2 -> frame 2 completes, frame 3 is not started.
- Change baud_div from 3 to 7 in the middle of a frame -> the current frame keeps 4 cycles per bit; the next frame uses 8 cycles per bit.
- Assert PRESET during DATA with TX=0 -> TX=1 in the same cycle, busy=0, and no frame_done pulse; after release with fifo_empty=0, the next frame starts with a new FETCH.
